reg_file_param: RTL and testbench

- Parametrised successor of the 8x8, two-read-port MIPS register file.
- Generalised in depth, width and read-port count.
- Adds an optional hardwired zero register and optional write-to-read bypass.
- Adds a sequential dump engine that streams every register over a valid/ready handshake to the board display/UART logic.
- Sits between the datapath (or the switch-driven test harness) and the Mod_Test debug outputs.

---
 rtl/reg_file_pkg.sv | 26 ++
 rtl/reg_dump_fsm.sv | 91 +++++++++
 rtl/reg_file_param.sv | 84 ++++++++
 tb/tb_reg_file_param.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and zero/bypass-aware lookup helper for reg_file_param
// Contents:
//   dump_state_t  : dump engine states
//   lookup_src_t  : where a register lookup takes its value from
//   lookup_src()  : picks the source for one lookup (read port or dump capture)
package reg_file_pkg;

  typedef enum logic [1:0] {IDLE, SEND, DONE} dump_state_t;

  typedef enum logic [1:0] {SRC_STORE, SRC_WD, SRC_ZERO} lookup_src_t;

  // The zero register wins over the bypass path.
  // A write to address 0 in $zero mode is therefore never forwarded.
  function automatic lookup_src_t lookup_src(
    input logic zero_reg,
    input logic bypass,
    input logic addr_is_zero,
    input logic we,
    input logic addr_hits_wa
  );
    if (zero_reg && addr_is_zero) return SRC_ZERO;
    if (bypass && we && addr_hits_wa) return SRC_WD;
    return SRC_STORE;
  endfunction

endpackage

// File: rtl/reg_dump_fsm.sv
// rtl/reg_dump_fsm.sv - sequential engine streaming every register over a valid/ready handshake
// Ports:
//   clk, reset               : clock, async active-high reset
//   dump_start               : one-cycle request, ignored while busy
//   dump_ready               : consumer accepts the presented word
//   lookup_addr/lookup_data  : single lookup port into the parent's storage
//   dump_valid/idx/data      : presented word
//   dump_busy, dump_done     : engine not idle / one-cycle end pulse
module reg_dump_fsm
  import reg_file_pkg::*;
#(
  parameter int NREGS = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dump_start,
  input  logic             dump_ready,
  output logic [AW-1:0]    lookup_addr,
  input  logic [WIDTH-1:0] lookup_data,
  output logic             dump_valid,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_busy,
  output logic             dump_done
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_t      state_q;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  // The only registers ever captured are 0 (on launch) and idx+1 (on an
  // accepted word), so one lookup port is enough. The wrap at LAST_IDX is
  // harmless: that handshake moves to DONE without capturing.
  assign lookup_addr = (state_q == SEND) ? idx_q + AW'(1) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dump_start) begin
            state_q <= SEND;
            idx_q   <= '0;
            data_q  <= lookup_data;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        SEND: begin
          // Without ready the word is frozen, even if its register is rewritten.
          if (dump_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= lookup_addr;
              data_q <= lookup_data;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dump_valid = valid_q;
  assign dump_idx   = idx_q;
  assign dump_data  = data_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised multi-port register file with zero register, bypass and dump engine
// Ports:
//   clk, reset          : clock, async active-high reset
//   we, wa, wd          : write port
//   ra, rd              : NREAD packed combinational read ports
//   dump_start/ready    : dump request / consumer handshake
//   dump_valid/idx/data : streamed register word
//   dump_busy/done      : dump engine status
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int NREGS    = 8,
  parameter int WIDTH    = 8,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [AW-1:0]          wa,
  input  logic [WIDTH-1:0]       wd,
  input  logic [NREAD*AW-1:0]    ra,
  output logic [NREAD*WIDTH-1:0] rd,
  input  logic                   dump_start,
  input  logic                   dump_ready,
  output logic                   dump_valid,
  output logic [AW-1:0]          dump_idx,
  output logic [WIDTH-1:0]       dump_data,
  output logic                   dump_busy,
  output logic                   dump_done
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             wr_en;
  logic [AW-1:0]    lk_addr;
  logic [WIDTH-1:0] lk_data;
  lookup_src_t      lk_src;

  assign wr_en = we && !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else if (wr_en) begin
      regs_q[wa] <= wd;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] addr;
    lookup_src_t   src;
    assign addr = ra[i*AW +: AW];
    assign src  = lookup_src(ZERO_REG != 0, BYPASS != 0, addr == '0, we, addr == wa);
    assign rd[i*WIDTH +: WIDTH] = (src == SRC_ZERO) ? '0 :
                                  (src == SRC_WD)   ? wd : regs_q[addr];
  end

  // Capture always sees a same-edge write, whatever BYPASS says, because the
  // captured word is the register's value after that edge.
  assign lk_src  = lookup_src(ZERO_REG != 0, 1'b1, lk_addr == '0, we, lk_addr == wa);
  assign lk_data = (lk_src == SRC_ZERO) ? '0 :
                   (lk_src == SRC_WD)   ? wd : regs_q[lk_addr];

  reg_dump_fsm #(
    .NREGS(NREGS),
    .WIDTH(WIDTH),
    .AW   (AW)
  ) u_dump (
    .clk        (clk),
    .reset      (reset),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .lookup_addr(lk_addr),
    .lookup_data(lk_data),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [2:0]  wa;
  logic [7:0]  wd;
  logic [5:0]  ra;
  logic        dump_start;
  logic        dump_ready;

  // Instance 0: plain, 1: ZERO_REG, 2: BYPASS, 3: ZERO_REG+BYPASS
  logic [15:0] rd_all [4];
  logic        dv     [4];
  logic [2:0]  didx   [4];
  logic [7:0]  ddata  [4];
  logic        dbusy  [4];
  logic        ddone  [4];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  reg_file_param #(.NREGS(8), .WIDTH(8), .NREAD(2), .ZERO_REG(0), .BYPASS(0)) dut_a (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_all[0]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv[0]),
    .dump_idx(didx[0]), .dump_data(ddata[0]), .dump_busy(dbusy[0]), .dump_done(ddone[0]));

  reg_file_param #(.NREGS(8), .WIDTH(8), .NREAD(2), .ZERO_REG(1), .BYPASS(0)) dut_z (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_all[1]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv[1]),
    .dump_idx(didx[1]), .dump_data(ddata[1]), .dump_busy(dbusy[1]), .dump_done(ddone[1]));

  reg_file_param #(.NREGS(8), .WIDTH(8), .NREAD(2), .ZERO_REG(0), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_all[2]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv[2]),
    .dump_idx(didx[2]), .dump_data(ddata[2]), .dump_busy(dbusy[2]), .dump_done(ddone[2]));

  reg_file_param #(.NREGS(8), .WIDTH(8), .NREAD(2), .ZERO_REG(1), .BYPASS(1)) dut_zb (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd_all[3]),
    .dump_start(dump_start), .dump_ready(dump_ready), .dump_valid(dv[3]),
    .dump_idx(didx[3]), .dump_data(ddata[3]), .dump_busy(dbusy[3]), .dump_done(ddone[3]));

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if ({dv[i], dbusy[i], ddone[i], didx[i], ddata[i]} !== 14'd0)
        $display("FAIL reset_dump[%0d]: got v%b b%b d%b idx%h data%h expected all 0",
                 i, dv[i], dbusy[i], ddone[i], didx[i], ddata[i]);
      else pass_cnt++;
      chk_cnt++;
      if (rd_all[i] !== 16'h0000)
        $display("FAIL reset_rd[%0d]: got %h expected 0000", i, rd_all[i]);
      else pass_cnt++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic_rw();
    write_reg(3'd1, 8'hCA);
    write_reg(3'd7, 8'hFE);
    write_reg(3'd0, 8'hDB);
    @(negedge clk);
    ra = {3'd0, 3'd1};
    #1;
    chk_cnt++;
    if (rd_all[0][7:0] !== 8'hCA) $display("FAIL rw_rd0_r1: got %h expected CA", rd_all[0][7:0]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_all[0][15:8] !== 8'hDB) $display("FAIL rw_rd1_r0: got %h expected DB", rd_all[0][15:8]);
    else pass_cnt++;
    ra = {3'd7, 3'd1};
    #1;
    chk_cnt++;
    if (rd_all[0][15:8] !== 8'hFE) $display("FAIL rw_rd1_r7: got %h expected FE", rd_all[0][15:8]);
    else pass_cnt++;
    ra = {3'd1, 3'd1};
    #1;
    chk_cnt++;
    if (rd_all[0] !== 16'hCACA) $display("FAIL rw_same_reg: got %h expected CACA", rd_all[0]);
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    ra = {3'd0, 3'd1};
    #1;
    chk_cnt++;
    if (rd_all[1] !== 16'h00CA) $display("FAIL zero_r0_ignored: got %h expected 00CA", rd_all[1]);
    else pass_cnt++;
    write_reg(3'd3, 8'h5A);
    @(negedge clk);
    ra = {3'd3, 3'd0};
    #1;
    chk_cnt++;
    if (rd_all[1] !== 16'h5A00) $display("FAIL zero_r3: got %h expected 5A00", rd_all[1]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_all[0] !== 16'h5ADB) $display("FAIL plain_r0_kept: got %h expected 5ADB", rd_all[0]);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we = 1'b1; wa = 3'd2; wd = 8'h77; ra = {3'd0, 3'd2};
    #1;
    chk_cnt++;
    if (rd_all[2] !== 16'hDB77) $display("FAIL bypass_hit: got %h expected DB77", rd_all[2]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_all[0][7:0] !== 8'h00) $display("FAIL nobypass_old: got %h expected 00", rd_all[0][7:0]);
    else pass_cnt++;
    @(posedge clk); #1;
    we = 1'b0;
    chk_cnt++;
    if (rd_all[0][7:0] !== 8'h77) $display("FAIL nobypass_after_edge: got %h expected 77", rd_all[0][7:0]);
    else pass_cnt++;
    @(negedge clk);
    we = 1'b1; wa = 3'd0; wd = 8'h99; ra = {3'd0, 3'd0};
    #1;
    chk_cnt++;
    if (rd_all[3] !== 16'h0000) $display("FAIL zero_beats_bypass: got %h expected 0000", rd_all[3]);
    else pass_cnt++;
    chk_cnt++;
    if (rd_all[2] !== 16'h9999) $display("FAIL bypass_r0: got %h expected 9999", rd_all[2]);
    else pass_cnt++;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_dump();
    int         words = 0;
    int         cyc = 0;
    logic [2:0] e_idx = 3'd0;
    logic [7:0] e_data;
    for (int k = 0; k < 8; k++) write_reg(3'(k), 8'h10 + 8'(k));
    @(negedge clk);
    dump_start = 1'b1; dump_ready = 1'b0;
    @(posedge clk); #1;
    dump_start = 1'b0;
    chk_cnt++;
    if (ddata[1] !== 8'h00) $display("FAIL dump_zero_capture: got %h expected 00", ddata[1]);
    else pass_cnt++;
    while (words < 8 && cyc < 100) begin
      dump_ready = (cyc % 2 == 0);
      dump_start = (cyc == 3);
      e_data = 8'h10 + {5'd0, e_idx};
      chk_cnt++;
      if (dv[0] !== 1'b1 || dbusy[0] !== 1'b1)
        $display("FAIL dump_valid_busy: got v%b b%b expected 1 1", dv[0], dbusy[0]);
      else pass_cnt++;
      chk_cnt++;
      if (didx[0] !== e_idx || ddata[0] !== e_data)
        $display("FAIL dump_word: got %h/%h expected %h/%h", didx[0], ddata[0], e_idx, e_data);
      else pass_cnt++;
      if (dump_ready) begin
        words++;
        e_idx = e_idx + 3'd1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dump_ready = 1'b0; dump_start = 1'b0;
    chk_cnt++;
    if (words != 8) $display("FAIL dump_timeout: got %0d words expected 8", words);
    else pass_cnt++;
    chk_cnt++;
    if ({ddone[0], dbusy[0], dv[0]} !== 3'b110)
      $display("FAIL dump_done_state: got done%b busy%b v%b expected 1 1 0", ddone[0], dbusy[0], dv[0]);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if ({ddone[0], dbusy[0], dv[0]} !== 3'b000)
      $display("FAIL dump_idle_after: got done%b busy%b v%b expected 0 0 0", ddone[0], dbusy[0], dv[0]);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (dv[0] !== 1'b0 || dbusy[0] !== 1'b0)
      $display("FAIL dump_no_restart: got v%b b%b expected 0 0", dv[0], dbusy[0]);
    else pass_cnt++;
  endtask

  task automatic test_mid_dump_write();
    logic done_seen = 1'b0;
    @(negedge clk);
    dump_start = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (didx[0] !== 3'd3 || ddata[0] !== 8'h13)
      $display("FAIL mid_reach_3: got %h/%h expected 3/13", didx[0], ddata[0]);
    else pass_cnt++;
    dump_ready = 1'b0; we = 1'b1; wa = 3'd3; wd = 8'hAA;
    @(posedge clk); #1;
    chk_cnt++;
    if (didx[0] !== 3'd3 || ddata[0] !== 8'h13)
      $display("FAIL mid_stall_hold: got %h/%h expected 3/13", didx[0], ddata[0]);
    else pass_cnt++;
    dump_ready = 1'b1; we = 1'b1; wa = 3'd4; wd = 8'hBB;
    @(posedge clk); #1;
    we = 1'b0;
    ra = {3'd0, 3'd3};
    chk_cnt++;
    if (didx[0] !== 3'd4 || ddata[0] !== 8'hBB)
      $display("FAIL mid_same_edge_capture: got %h/%h expected 4/BB", didx[0], ddata[0]);
    else pass_cnt++;
    #1;
    chk_cnt++;
    if (rd_all[0][7:0] !== 8'hAA) $display("FAIL mid_datapath_write: got %h expected AA", rd_all[0][7:0]);
    else pass_cnt++;
    for (int c = 0; c < 20 && !done_seen; c++) begin
      @(posedge clk); #1;
      if (ddone[0]) done_seen = 1'b1;
    end
    chk_cnt++;
    if (!done_seen) $display("FAIL mid_done_timeout: got no dump_done expected pulse");
    else pass_cnt++;
    dump_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_dump();
    @(negedge clk);
    dump_start = 1'b1; dump_ready = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_cnt++;
    if (didx[0] !== 3'd5 || ddata[0] !== 8'h15)
      $display("FAIL rst_reach_5: got %h/%h expected 5/15", didx[0], ddata[0]);
    else pass_cnt++;
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({dv[0], dbusy[0], ddone[0], didx[0], ddata[0]} !== 14'd0)
      $display("FAIL rst_async_outputs: got v%b b%b d%b idx%h data%h expected all 0",
               dv[0], dbusy[0], ddone[0], didx[0], ddata[0]);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b0; dump_ready = 1'b0; ra = {3'd7, 3'd1};
    @(posedge clk); #1;
    chk_cnt++;
    if (rd_all[0] !== 16'h0000 || rd_all[2] !== 16'h0000)
      $display("FAIL rst_reads_zero: got %h %h expected 0000 0000", rd_all[0], rd_all[2]);
    else pass_cnt++;
    chk_cnt++;
    if (dv[0] !== 1'b0 || dbusy[0] !== 1'b0)
      $display("FAIL rst_stays_idle: got v%b b%b expected 0 0", dv[0], dbusy[0]);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0;
    dump_start = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_basic_rw();
    test_zero_reg();
    test_bypass();
    test_dump();
    test_mid_dump_write();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
